// File: rtl/seven_segment_capture.sv
// seven_segment_capture
//   Recovers the value shown on each digit of a multiplexed, active-low
//   seven-segment bus. Patterns are synchronised, held to a stability filter,
//   then decoded and latched into per-digit result registers.
//
//   Ports
//     i_clk             system clock
//     i_rst             asynchronous reset, active-high
//     i_sevenSegmentLed segment bus {a,b,c,d,e,f,g,h}, active-low, h = dp at bit 0
//     i_enable          digit enables, active-low, bit k selects digit k
//     o_digits          decoded code of digit k at [4k+3:4k] (F = blank, E = illegal)
//     o_dp              captured decimal point of digit k, 1 = lit
//     o_digitValid      digit k captured since the last frame
//     o_frameValid      1-cycle pulse once every digit has been captured
//     o_decodeError     1-cycle pulse when a captured pattern was illegal
//
//   state     | meaning
//   ST_IDLE   | no single digit selected on the bus
//   ST_TRACK  | one digit selected, counting identical consecutive samples
//   ST_CAPTURED | current sample already latched, waiting for it to change
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_sevenSegmentLed,
  input  logic [NUM_DIGITS-1:0]   i_enable,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]   o_dp,
  output logic [NUM_DIGITS-1:0]   o_digitValid,
  output logic                    o_frameValid,
  output logic                    o_decodeError
);

  localparam int SW = NUM_DIGITS + 8;
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRACK    = 2'd1,
    ST_CAPTURED = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [SW-1:0]           r_sync1;
  logic [SW-1:0]           r_sync2;
  logic [SW-1:0]           r_prev;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_digitValid;
  logic                    r_frameValid;
  logic                    r_decodeError;

  logic [NUM_DIGITS-1:0]   w_en;
  logic [7:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_low;
  logic                    w_sel;
  logic [IW-1:0]           w_idx;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_same;
  logic                    w_capture;
  logic [3:0]              w_code;
  logic [NUM_DIGITS-1:0]   w_valid_base;

  assign w_en   = r_sync2[SW-1:8];
  assign w_seg  = r_sync2[7:0];
  assign w_low  = ~w_en;
  // Exactly one enable low: non-zero and a power of two.
  assign w_sel  = (w_low != '0) && ((w_low & (w_low - NUM_DIGITS'(1))) == '0);
  assign w_same = (r_sync2 == r_prev);
  assign w_onehot = NUM_DIGITS'(1) << w_idx;

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_low[k]) w_idx = IW'(k);
    end
  end

  always_comb begin
    w_code = 4'hE;
    case (w_seg[7:1])
      7'b0000001: w_code = 4'h0;
      7'b1001111: w_code = 4'h1;
      7'b0010010: w_code = 4'h2;
      7'b0000110: w_code = 4'h3;
      7'b1001100: w_code = 4'h4;
      7'b0100100: w_code = 4'h5;
      7'b0100000: w_code = 4'h6;
      7'b0001111: w_code = 4'h7;
      7'b0000000: w_code = 4'h8;
      7'b0001100: w_code = 4'h9;
      7'b1111111: w_code = 4'hF;
      default:    w_code = 4'hE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {i_enable, i_sevenSegmentLed};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_sel) w_state_nxt = ST_TRACK;
      end
      ST_TRACK: begin
        if (!w_sel) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (!w_same) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CW'(STABLE_CYCLES - 2)) begin
          // This increment makes the count reach STABLE_CYCLES-1.
          w_cnt_nxt   = CW'(STABLE_CYCLES - 1);
          w_capture   = 1'b1;
          w_state_nxt = ST_CAPTURED;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_CAPTURED: begin
        if (!w_sel) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (!w_same) begin
          w_state_nxt = ST_TRACK;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A full set of valid bits is consumed by the frame pulse on the next edge.
  assign w_valid_base = (&r_digitValid) ? '0 : r_digitValid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_digits      <= '1;
      r_dp          <= '0;
      r_digitValid  <= '0;
      r_frameValid  <= 1'b0;
      r_decodeError <= 1'b0;
    end else begin
      r_frameValid  <= &r_digitValid;
      r_decodeError <= w_capture && (w_code == 4'hE);
      r_digitValid  <= w_valid_base | (w_capture ? w_onehot : '0);
      if (w_capture) begin
        r_digits[w_idx*4 +: 4] <= w_code;
        r_dp[w_idx]            <= ~w_seg[0];
      end
    end
  end

  assign o_digits      = r_digits;
  assign o_dp          = r_dp;
  assign o_digitValid  = r_digitValid;
  assign o_frameValid  = r_frameValid;
  assign o_decodeError = r_decodeError;

endmodule

// File: tb/tb_seven_segment_capture.sv
module tb_seven_segment_capture;

  logic        clk;
  logic        rst;
  logic [7:0]  seg;
  logic [2:0]  en;
  logic [11:0] digits;
  logic [2:0]  dp;
  logic [2:0]  valid;
  logic        frame;
  logic        err;

  typedef struct {
    int         idx;
    logic [3:0] code;
    logic       dp;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   frame_seen = 0;
  int   err_seen = 0;
  logic [2:0] prev_valid = '0;

  seven_segment_capture #(.NUM_DIGITS(3), .STABLE_CYCLES(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_sevenSegmentLed(seg),
    .i_enable(en),
    .o_digits(digits),
    .o_dp(dp),
    .o_digitValid(valid),
    .o_frameValid(frame),
    .o_decodeError(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(int idx, logic [3:0] code, logic d, logic e);
    exp_t x;
    x.idx = idx; x.code = code; x.dp = d; x.err = e;
    return x;
  endfunction

  // One clock step; captures appear as a newly set valid bit or an error pulse
  // and are matched against the oldest expected capture.
  task automatic tick();
    logic [2:0] rising;
    exp_t e;
    @(posedge clk);
    #1;
    rising = valid & ~prev_valid;
    if (rising != 3'b000 || err) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_capture valid=%b err=%b digits=%h", valid, err, digits);
      end else begin
        e = sb.pop_front();
        if (rising !== (3'(1) << e.idx) || digits[e.idx*4 +: 4] !== e.code ||
            dp[e.idx] !== e.dp || err !== e.err) begin
          bad++;
          $display("FAIL capture got rise=%b code=%h dp=%b err=%b want idx=%0d code=%h dp=%b err=%b",
                   rising, digits[e.idx*4 +: 4], dp[e.idx], err, e.idx, e.code, e.dp, e.err);
        end
      end
    end
    prev_valid = valid;
    if (frame) frame_seen++;
    if (err) err_seen++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    prev_valid = '0;
    frame_seen = 0;
    err_seen = 0;
  endtask

  task automatic test_reset();
    en = 3'b110; seg = 8'b0000_0011;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({digits, dp, valid, frame, err} !== {12'hFFF, 3'b000, 3'b000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got digits=%h dp=%b valid=%b frame=%b err=%b", digits, dp, valid, frame, err);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete(); prev_valid = '0; frame_seen = 0; err_seen = 0;
    sb.push_back(mk(0, 4'h0, 1'b0, 1'b0));
    for (int e = 1; e <= 6; e++) begin
      tick();
      total++;
      if (valid !== ((e < 6) ? 3'b000 : 3'b001)) begin
        bad++;
        $display("FAIL reset_latency edge=%0d valid=%b", e, valid);
      end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL reset_pending got=%0d want=0", sb.size()); end
  endtask

  task automatic test_single_digit();
    en = 3'b110; seg = 8'b0000_0011;
    do_reset();
    sb.push_back(mk(0, 4'h0, 1'b0, 1'b0));
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 5) begin
        total++;
        if (digits[3:0] !== 4'hF) begin bad++; $display("FAIL single_early got=%h want=f", digits[3:0]); end
      end
      if (e == 6) begin
        total++;
        if (digits[3:0] !== 4'h0) begin bad++; $display("FAIL single_edge6 got=%h want=0", digits[3:0]); end
      end
    end
    total++;
    if (dp[0] !== 1'b0 || valid !== 3'b001 || digits !== 12'hFF0) begin
      bad++;
      $display("FAIL single_hold dp=%b valid=%b digits=%h want dp0=0 valid=001 digits=ff0", dp, valid, digits);
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL single_pending got=%0d want=0", sb.size()); end
  endtask

  task automatic test_scan();
    en = 3'b110; seg = 8'b1001_1110;
    do_reset();
    sb.push_back(mk(0, 4'h1, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++) tick();
    en = 3'b101; seg = 8'b0010_0101;
    sb.push_back(mk(1, 4'h2, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) tick();
    en = 3'b011; seg = 8'b0001_1001;
    sb.push_back(mk(2, 4'h9, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (digits !== 12'h921 || dp !== 3'b001) begin
      bad++;
      $display("FAIL scan_value digits=%h dp=%b want 921 001", digits, dp);
    end
    total++;
    if (frame_seen != 1 || valid !== 3'b000) begin
      bad++;
      $display("FAIL scan_frame pulses=%0d valid=%b want 1 000", frame_seen, valid);
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scan_pending got=%0d want=0", sb.size()); end
  endtask

  // Runs straight after test_scan: digit 2 still shows "9" and the frame is done.
  task automatic test_glitch();
    sb.push_back(mk(2, 4'h9, 1'b0, 1'b0));
    seg = 8'b0000_1101;
    for (int i = 0; i < 3; i++) tick();
    seg = 8'b0001_1001;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) begin
        total++;
        if (valid !== 3'b000 || digits !== 12'h921) begin
          bad++;
          $display("FAIL glitch_hold valid=%b digits=%h want 000 921", valid, digits);
        end
      end
    end
    total++;
    if (valid !== 3'b100 || digits !== 12'h921 || frame_seen != 1) begin
      bad++;
      $display("FAIL glitch_recapture valid=%b digits=%h frames=%0d want 100 921 1", valid, digits, frame_seen);
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL glitch_pending got=%0d want=0", sb.size()); end
  endtask

  task automatic test_no_select();
    en = 3'b100; seg = 8'b0000_0001;
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (valid !== 3'b000 || digits !== 12'hFFF) begin
      bad++;
      $display("FAIL nosel_two valid=%b digits=%h want 000 fff", valid, digits);
    end
    en = 3'b111;
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (valid !== 3'b000 || digits !== 12'hFFF || frame_seen != 0) begin
      bad++;
      $display("FAIL nosel_none valid=%b digits=%h frames=%0d want 000 fff 0", valid, digits, frame_seen);
    end
  endtask

  task automatic test_decode_error();
    en = 3'b101; seg = 8'b0110_0001;
    do_reset();
    sb.push_back(mk(1, 4'hE, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (digits[7:4] !== 4'hE || err_seen != 1) begin
      bad++;
      $display("FAIL decode_error code=%h pulses=%0d want e 1", digits[7:4], err_seen);
    end
    seg = 8'b1111_1111;
    err_seen = 0;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (digits[7:4] !== 4'hF || err_seen != 0 || dp[1] !== 1'b0) begin
      bad++;
      $display("FAIL decode_blank code=%h pulses=%0d dp=%b want f 0 0", digits[7:4], err_seen, dp[1]);
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL decode_pending got=%0d want=0", sb.size()); end
  endtask

  initial begin
    rst = 1'b1;
    en  = 3'b111;
    seg = 8'hFF;
    #12;
    test_reset();
    test_single_digit();
    test_scan();
    test_glitch();
    test_no_select();
    test_decode_error();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
